// File: rtl/ibex_rf_wport_ctrl.sv
// Register-file write-port controller: zeroes x1..xN after reset, then
// round-robin arbitrates two writeback requesters onto one registered write port.
module ibex_rf_wport_ctrl #(
   parameter bit          RV32E        = 1'b0,
   parameter int unsigned DataWidth    = 32,
   parameter bit          ClearOnReset = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req0_valid_i,
   output logic                 req0_ready_o,
   input  logic [4:0]           req0_addr_i,
   input  logic [DataWidth-1:0] req0_data_i,
   input  logic                 req1_valid_i,
   output logic                 req1_ready_o,
   input  logic [4:0]           req1_addr_i,
   input  logic [DataWidth-1:0] req1_data_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 init_done_o,
   output logic                 illegal_addr_o
);

   localparam int unsigned NumWords = RV32E ? 16 : 32;
   localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

   localparam logic [0:0] StClear = 1'b0;
   localparam logic [0:0] StRun   = 1'b1;

   logic [0:0]           state_q;
   logic [4:0]           cnt_q;
   logic                 last_grant_q;
   logic                 run;
   logic                 accept;
   logic [4:0]           sel_addr;
   logic [DataWidth-1:0] sel_data;
   logic                 addr_oob;

   assign run         = (state_q == StRun);
   assign init_done_o = run;

   // Under contention the requester that did not win last time is granted.
   always_comb begin
      req0_ready_o = run & req0_valid_i & (~req1_valid_i | last_grant_q);
      req1_ready_o = run & req1_valid_i & (~req0_valid_i | ~last_grant_q);
      accept       = req0_ready_o | req1_ready_o;
      sel_addr     = req1_ready_o ? req1_addr_i : req0_addr_i;
      sel_data     = req1_ready_o ? req1_data_i : req0_data_i;
      addr_oob     = RV32E && sel_addr[4];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ClearOnReset ? StClear : StRun;
         cnt_q          <= 5'd1;
         last_grant_q   <= 1'b1;
         rf_we_o        <= 1'b0;
         rf_waddr_o     <= '0;
         rf_wdata_o     <= '0;
         illegal_addr_o <= 1'b0;
      end else if (state_q == StClear) begin
         // Sweep starts at x1; x0 is hardwired zero and never written.
         rf_we_o        <= 1'b1;
         rf_waddr_o     <= cnt_q;
         rf_wdata_o     <= '0;
         illegal_addr_o <= 1'b0;
         cnt_q          <= cnt_q + 5'd1;
         if (cnt_q == LastAddr) begin
            state_q <= StRun;
         end
      end else if (accept) begin
         rf_we_o        <= (sel_addr != 5'd0) && !addr_oob;
         rf_waddr_o     <= sel_addr;
         rf_wdata_o     <= sel_data;
         illegal_addr_o <= addr_oob;
         last_grant_q   <= req1_ready_o;
      end else begin
         rf_we_o        <= 1'b0;
         illegal_addr_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ibex_rf_wport_ctrl.sv
// Scoreboard bench for ibex_rf_wport_ctrl: one RV32I and one RV32E instance,
// one active at a time; stimulus queues expected outputs, a monitor pops them.
module tb_ibex_rf_wport_ctrl;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ill;
      logic        init;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst0 = 1'b1;
   logic        rst1 = 1'b1;
   bit          sel = 1'b0;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [4:0]  a0 = '0, a1 = '0;
   logic [31:0] d0 = '0, d1 = '0;

   logic        r0_0, r1_0, we_0, id_0, il_0;
   logic [4:0]  wa_0;
   logic [31:0] wd_0;
   logic        r0_1, r1_1, we_1, id_1, il_1;
   logic [4:0]  wa_1;
   logic [31:0] wd_1;

   logic        m_rst, m_r0, m_r1, m_we, m_id, m_il;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [4:0]  last_a = '0;
   logic [31:0] last_d = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ibex_rf_wport_ctrl #(.RV32E(1'b0), .DataWidth(32), .ClearOnReset(1'b1)) u_i (
      .clk_i(clk), .rst_ni(rst0),
      .req0_valid_i(v0), .req0_ready_o(r0_0), .req0_addr_i(a0), .req0_data_i(d0),
      .req1_valid_i(v1), .req1_ready_o(r1_0), .req1_addr_i(a1), .req1_data_i(d1),
      .rf_we_o(we_0), .rf_waddr_o(wa_0), .rf_wdata_o(wd_0),
      .init_done_o(id_0), .illegal_addr_o(il_0)
   );

   ibex_rf_wport_ctrl #(.RV32E(1'b1), .DataWidth(32), .ClearOnReset(1'b1)) u_e (
      .clk_i(clk), .rst_ni(rst1),
      .req0_valid_i(v0), .req0_ready_o(r0_1), .req0_addr_i(a0), .req0_data_i(d0),
      .req1_valid_i(v1), .req1_ready_o(r1_1), .req1_addr_i(a1), .req1_data_i(d1),
      .rf_we_o(we_1), .rf_waddr_o(wa_1), .rf_wdata_o(wd_1),
      .init_done_o(id_1), .illegal_addr_o(il_1)
   );

   assign m_rst = sel ? rst1 : rst0;
   assign m_r0  = sel ? r0_1 : r0_0;
   assign m_r1  = sel ? r1_1 : r1_0;
   assign m_we  = sel ? we_1 : we_0;
   assign m_id  = sel ? id_1 : id_0;
   assign m_il  = sel ? il_1 : il_0;
   assign m_wa  = sel ? wa_1 : wa_0;
   assign m_wd  = sel ? wd_1 : wd_0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs update on every edge; pop the expectation for that edge.
   always begin
      @(posedge clk);
      #1;
      if (m_rst === 1'b1) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("rf_we", 32'(m_we), 32'(mon_e.we));
            chk("rf_waddr", 32'(m_wa), 32'(mon_e.addr));
            chk("rf_wdata", m_wd, mon_e.data);
            chk("illegal_addr", 32'(m_il), 32'(mon_e.ill));
            chk("init_done", 32'(m_id), 32'(mon_e.init));
         end else begin
            chk("idle_we", 32'(m_we), 32'd0);
            chk("idle_illegal", 32'(m_il), 32'd0);
         end
      end
   end

   task automatic rstchk();
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("rst_we", 32'(m_we), 32'd0);
      chk("rst_waddr", 32'(m_wa), 32'd0);
      chk("rst_wdata", m_wd, 32'd0);
      chk("rst_illegal", 32'(m_il), 32'd0);
      chk("rst_init_done", 32'(m_id), 32'd0);
      chk("rst_ready0", 32'(m_r0), 32'd0);
      chk("rst_ready1", 32'(m_r1), 32'd0);
      last_a = '0;
      last_d = '0;
   endtask

   task automatic sweep(input int n, input int nw);
      exp_t e;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         #1;
         if (i == 1) begin
            if (sel) rst1 = 1'b1; else rst0 = 1'b1;
         end
         v0 = 1'b1; v1 = 1'b1; a0 = 5'd9; a1 = 5'd9; d0 = 32'h99; d1 = 32'h99;
         #1;
         chk("sweep_ready0", 32'(m_r0), 32'd0);
         chk("sweep_ready1", 32'(m_r1), 32'd0);
         e.we = 1'b1; e.addr = 5'(i); e.data = '0; e.ill = 1'b0; e.init = (i == nw - 1);
         exp_q.push_back(e);
         last_a = 5'(i);
         last_d = '0;
      end
   endtask

   task automatic cyc(input logic rv0, input logic [4:0] ra0, input logic [31:0] rd0,
                      input logic rv1, input logic [4:0] ra1, input logic [31:0] rd1,
                      input logic g0, input logic g1);
      exp_t e;
      @(negedge clk);
      #1;
      v0 = rv0; a0 = ra0; d0 = rd0; v1 = rv1; a1 = ra1; d1 = rd1;
      #1;
      chk("ready0", 32'(m_r0), 32'(g0));
      chk("ready1", 32'(m_r1), 32'(g1));
      e.init = 1'b1;
      if (g0 || g1) begin
         e.addr = g1 ? ra1 : ra0;
         e.data = g1 ? rd1 : rd0;
         e.ill  = sel && e.addr[4];
         e.we   = (e.addr != 5'd0) && !e.ill;
         last_a = e.addr;
         last_d = e.data;
      end else begin
         e.we = 1'b0; e.ill = 1'b0; e.addr = last_a; e.data = last_d;
      end
      exp_q.push_back(e);
   endtask

   initial begin
      #2;
      rst0 = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);
      #1;
      rstchk();

      // RV32I: full sweep, then arbitration
      sweep(31, 32);
      cyc(1, 5'd3, 32'hA0000003, 1, 5'd7, 32'hB0000007, 1, 0);
      cyc(1, 5'd3, 32'hA0000003, 1, 5'd7, 32'hB0000007, 0, 1);
      cyc(1, 5'd3, 32'hA0000003, 1, 5'd7, 32'hB0000007, 1, 0);
      cyc(1, 5'd3, 32'hA0000003, 1, 5'd7, 32'hB0000007, 0, 1);
      cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      cyc(0, 5'd0, 32'h0, 1, 5'd20, 32'h55, 0, 1);
      cyc(1, 5'd2, 32'h22, 1, 5'd4, 32'h44, 1, 0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

      // Reset mid-sweep, then a complete sweep and a grant order from reset
      @(negedge clk);
      #1;
      rst0 = 1'b0;
      rstchk();
      sweep(10, 32);
      @(negedge clk);
      #1;
      rst0 = 1'b0;
      rstchk();
      chk("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
      sweep(31, 32);
      cyc(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

      // RV32E instance
      @(negedge clk);
      #1;
      rst0 = 1'b0;
      sel = 1'b1;
      rstchk();
      sweep(15, 16);
      cyc(1, 5'd17, 32'hCAFE0017, 0, 5'd0, 32'h0, 1, 0);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      cyc(1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 0);
      cyc(0, 5'd0, 32'h0, 1, 5'd31, 32'h31, 0, 1);
      cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

      repeat (3) @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
